// File: rtl/microwave_ctrl.sv
// Microwave front-panel controller: keypad setpoint entry, timer sequencing,
// door interlock, magnetron power duty cycle and end-of-cook beeper.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   key_valid, key_code keypad strobe and code (0-9 digit, 10 clear,
//                       11 quick 00:30 start, 12 power step)
//   start_btn, stop_btn level buttons, rising-edge detected here
//   door_open           synchronised door switch, 1 = open
//   timer_done          timer idle flag from the countdown timer
//   timer_start/pause/stop  one-cycle registered command pulses to the timer
//   min, sec            setpoint to the timer (sec saturated to 59)
//   magnetron, lamp, beep, power  panel/cavity outputs
module microwave_ctrl #(
    parameter int POWER_TICK  = 5000000,
    parameter int BEEP_CYCLES = 100000000,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       door_open,
    input  logic       timer_done,
    output logic       timer_start,
    output logic       timer_pause,
    output logic       timer_stop,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic       magnetron,
    output logic       lamp,
    output logic       beep,
    output logic [3:0] power
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_COOK,
        S_PAUSED,
        S_RESUME,
        S_FINISH
    } state_t;

    localparam int TW = (POWER_TICK > 1) ? $clog2(POWER_TICK) : 1;
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam int AW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(POWER_TICK - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);
    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_TIMEOUT - 1);

    // Digits d3..d0 packed so dig[3] is the tens-of-minutes digit.
    localparam logic [3:0][3:0] QUICK_SET = {4'd0, 4'd0, 4'd3, 4'd0};

    state_t           state_q, state_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic [3:0]       pwr_q, pwr_d;
    logic [6:0]       min_q, min_d;
    logic [6:0]       sec_q, sec_d;
    logic [AW-1:0]    arm_cnt_q, arm_cnt_d;
    logic [BW-1:0]    beep_cnt_q, beep_cnt_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [3:0]       slot_q, slot_d;
    logic             start_q, start_d;
    logic             pause_q, pause_d;
    logic             stop_q, stop_d;
    logic             mag_q, mag_d;
    logic             lamp_q, lamp_d;
    logic             beep_q, beep_d;
    logic             start_prev_q, stop_prev_q;

    logic start_ev, stop_ev;
    logic key_digit, key_clear, key_quick, key_power;
    logic setpt_nz;
    logic [6:0] sec_raw;

    function automatic logic [6:0] two_dig(input logic [3:0] hi,
                                           input logic [3:0] lo);
        return 7'(hi) * 7'd10 + 7'(lo);
    endfunction

    assign start_ev  = start_btn & ~start_prev_q;
    assign stop_ev   = stop_btn & ~stop_prev_q;
    assign key_digit = key_code <= 4'd9;
    assign key_clear = key_code == 4'd10;
    assign key_quick = key_code == 4'd11;
    assign key_power = key_code == 4'd12;
    assign setpt_nz  = dig_q != '0;

    always_comb begin
        state_d    = state_q;
        dig_d      = dig_q;
        pwr_d      = pwr_q;
        arm_cnt_d  = '0;
        beep_cnt_d = '0;
        start_d    = 1'b0;
        pause_d    = 1'b0;
        stop_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (stop_ev) begin
                    dig_d = '0;
                end else if (start_ev) begin
                    if (!door_open && setpt_nz) begin
                        start_d = 1'b1;
                        state_d = S_ARM;
                    end
                end else if (key_valid) begin
                    unique case (1'b1)
                        key_digit: dig_d = {dig_q[2:0], key_code};
                        key_clear: dig_d = '0;
                        key_quick: begin
                            if (!door_open) begin
                                dig_d   = QUICK_SET;
                                start_d = 1'b1;
                                state_d = S_ARM;
                            end
                        end
                        key_power: begin
                            pwr_d = (pwr_q == 4'd1) ? 4'd10
                                                    : pwr_q - 4'd1;
                        end
                        default: ;
                    endcase
                end
            end
            S_ARM: begin
                // The timer sees our start pulse one cycle late, so
                // done is allowed a bounded window to fall.
                if (stop_ev) begin
                    stop_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (!timer_done) begin
                    state_d = S_COOK;
                end else if (arm_cnt_q == ARM_LAST) begin
                    stop_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            S_COOK: begin
                if (stop_ev) begin
                    stop_d  = 1'b1;
                    dig_d   = '0;
                    state_d = S_IDLE;
                end else if (door_open) begin
                    pause_d = 1'b1;
                    state_d = S_PAUSED;
                end else if (timer_done) begin
                    state_d = S_FINISH;
                end
            end
            S_PAUSED: begin
                if (stop_ev) begin
                    stop_d  = 1'b1;
                    dig_d   = '0;
                    state_d = S_IDLE;
                end else if (start_ev && !door_open) begin
                    start_d = 1'b1;
                    state_d = S_RESUME;
                end
            end
            S_RESUME: begin
                // A paused timer already reports done = 0.
                if (stop_ev) begin
                    stop_d  = 1'b1;
                    dig_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_COOK;
                end
            end
            S_FINISH: begin
                if (stop_ev || door_open) begin
                    state_d = S_IDLE;
                end else if (beep_cnt_q == BEEP_LAST) begin
                    dig_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        min_d   = two_dig(dig_d[3], dig_d[2]);
        sec_raw = two_dig(dig_d[1], dig_d[0]);
        sec_d   = (sec_raw > 7'd59) ? 7'd59 : sec_raw;
        beep_d  = state_d == S_FINISH;
        lamp_d  = (state_d == S_COOK) || (state_d == S_PAUSED);
        // Duty window restarts at slot 0 on every entry to COOK.
        tick_d  = '0;
        slot_d  = '0;
        if (state_d == S_COOK && state_q == S_COOK) begin
            if (tick_q == TICK_LAST) begin
                slot_d = (slot_q == 4'd9) ? 4'd0 : slot_q + 4'd1;
            end else begin
                tick_d = tick_q + 1'b1;
                slot_d = slot_q;
            end
        end
        mag_d = (state_d == S_COOK) && (slot_d < pwr_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dig_q        <= '0;
            pwr_q        <= 4'd10;
            min_q        <= '0;
            sec_q        <= '0;
            arm_cnt_q    <= '0;
            beep_cnt_q   <= '0;
            tick_q       <= '0;
            slot_q       <= '0;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            stop_q       <= 1'b0;
            mag_q        <= 1'b0;
            lamp_q       <= 1'b0;
            beep_q       <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dig_q        <= dig_d;
            pwr_q        <= pwr_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            arm_cnt_q    <= arm_cnt_d;
            beep_cnt_q   <= beep_cnt_d;
            tick_q       <= tick_d;
            slot_q       <= slot_d;
            start_q      <= start_d;
            pause_q      <= pause_d;
            stop_q       <= stop_d;
            mag_q        <= mag_d;
            lamp_q       <= lamp_d;
            beep_q       <= beep_d;
            start_prev_q <= start_btn;
            stop_prev_q  <= stop_btn;
        end
    end

    assign timer_start = start_q;
    assign timer_pause = pause_q;
    assign timer_stop  = stop_q;
    assign min         = min_q;
    assign sec         = sec_q;
    // The door cuts the magnetron without waiting for a clock edge.
    assign magnetron   = mag_q & ~door_open;
    assign lamp        = lamp_q | door_open;
    assign beep        = beep_q;
    assign power       = pwr_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: random keypad/power stimulus against a
// decimal-setpoint model plus directed cook, door, finish and abort flows.
module tb_microwave_ctrl;

    localparam int PT = 4;
    localparam int BC = 20;
    localparam int AT = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start_btn;
    logic       stop_btn;
    logic       door_open;
    logic       timer_done;
    logic       timer_start;
    logic       timer_pause;
    logic       timer_stop;
    logic [6:0] min;
    logic [6:0] sec;
    logic       magnetron;
    logic       lamp;
    logic       beep;
    logic [3:0] power;

    int vectors = 0;
    int miscompares = 0;
    int m_val = 0;
    int m_pwr = 10;

    microwave_ctrl #(
        .POWER_TICK (PT),
        .BEEP_CYCLES(BC),
        .ARM_TIMEOUT(AT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .start_btn  (start_btn),
        .stop_btn   (stop_btn),
        .door_open  (door_open),
        .timer_done (timer_done),
        .timer_start(timer_start),
        .timer_pause(timer_pause),
        .timer_stop (timer_stop),
        .min        (min),
        .sec        (sec),
        .magnetron  (magnetron),
        .lamp       (lamp),
        .beep       (beep),
        .power      (power)
    );

    always #5 clock = ~clock;

    function automatic int exp_min();
        return m_val / 100;
    endfunction

    function automatic int exp_sec();
        return (m_val % 100 > 59) ? 59 : m_val % 100;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Key press in IDLE; the model holds the setpoint as a 4-digit number.
    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
        key_code  = 4'd0;
        if (k <= 4'd9) m_val = (m_val * 10 + int'(k)) % 10000;
        else if (k == 4'd10) m_val = 0;
        else if (k == 4'd12) m_pwr = (m_pwr == 1) ? 10 : m_pwr - 1;
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    task automatic stop_cook();
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
        m_val = 0;
        vectors++;
        if (timer_stop !== 1'b1 || timer_start !== 1'b0 ||
            timer_pause !== 1'b0 || min !== 7'd0 || sec !== 7'd0) begin
            miscompares++;
            $display("FAIL stop_cook stop=%b start=%b pause=%b %0d:%0d want 1 0 0 0:0",
                     timer_stop, timer_start, timer_pause, min, sec);
        end
        timer_done = 1'b1;
        step();
    endtask

    task automatic test_reset();
        vectors++;
        if (min !== 7'd0 || sec !== 7'd0 || power !== 4'd10 ||
            {timer_start, timer_pause, timer_stop} !== 3'b000 ||
            {magnetron, lamp, beep} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state %0d:%0d pwr=%0d pulses=%b%b%b mlb=%b%b%b want 0:0 10 000 000",
                     min, sec, power, timer_start, timer_pause, timer_stop,
                     magnetron, lamp, beep);
        end
    endtask

    task automatic test_entry();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        vectors++;
        if (min !== 7'd12 || sec !== 7'd34) begin
            miscompares++;
            $display("FAIL entry_setpoint got %0d:%0d want 12:34", min, sec);
        end
        press_start();
        vectors++;
        if (timer_start !== 1'b1) begin
            miscompares++;
            $display("FAIL entry_start got %b want 1", timer_start);
        end
        timer_done = 1'b0;
        step();
        vectors++;
        if (timer_start !== 1'b0 || magnetron !== 1'b1 || lamp !== 1'b1) begin
            miscompares++;
            $display("FAIL entry_cook start=%b mag=%b lamp=%b want 0 1 1",
                     timer_start, magnetron, lamp);
        end
        stop_cook();
    endtask

    task automatic test_digits_random();
        press(4'd10);
        for (int i = 0; i < 24; i++) begin
            press(4'($urandom_range(0, 9)));
            vectors++;
            if (min !== 7'(exp_min()) || sec !== 7'(exp_sec())) begin
                miscompares++;
                $display("FAIL digit_shift got %0d:%0d want %0d:%0d",
                         min, sec, exp_min(), exp_sec());
            end
        end
        press(4'd0); press(4'd0); press(4'd9); press(4'd9);
        vectors++;
        if (min !== 7'd0 || sec !== 7'd59) begin
            miscompares++;
            $display("FAIL sec_saturate got %0d:%0d want 0:59", min, sec);
        end
        press(4'd10);
        vectors++;
        if (min !== 7'd0 || sec !== 7'd0) begin
            miscompares++;
            $display("FAIL clear got %0d:%0d want 0:0", min, sec);
        end
        press_start();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (timer_start !== 1'b0 || lamp !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_start start=%b lamp=%b want 0 0",
                         timer_start, lamp);
            end
            step();
        end
        press(4'd1);
        door_open = 1'b1;
        press_start();
        vectors++;
        if (timer_start !== 1'b0 || lamp !== 1'b1) begin
            miscompares++;
            $display("FAIL door_open_start start=%b lamp=%b want 0 1",
                     timer_start, lamp);
        end
        door_open = 1'b0;
        step();
        press(4'd5);
        vectors++;
        if (min !== 7'(exp_min()) || sec !== 7'(exp_sec())) begin
            miscompares++;
            $display("FAIL still_idle got %0d:%0d want %0d:%0d",
                     min, sec, exp_min(), exp_sec());
        end
        press(4'd10);
    endtask

    task automatic test_power_duty();
        int on;
        logic exp_m;
        while (m_pwr != 3) press(4'd12);
        vectors++;
        if (power !== 4'd3) begin
            miscompares++;
            $display("FAIL power_step got %0d want 3", power);
        end
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                repeat ($urandom_range(1, 9)) press(4'd12);
                vectors++;
                if (power !== 4'(m_pwr)) begin
                    miscompares++;
                    $display("FAIL power_rand got %0d want %0d", power, m_pwr);
                end
            end
            press(4'd10); press(4'd1); press(4'd0); press(4'd0);
            press_start();
            timer_done = 1'b0;
            step();
            on = 0;
            for (int c = 0; c < 20 * PT; c++) begin
                exp_m = ((c / PT) % 10) < m_pwr;
                vectors++;
                if (magnetron !== exp_m) begin
                    miscompares++;
                    $display("FAIL duty_cycle c=%0d got %b want %b",
                             c, magnetron, exp_m);
                end
                if (magnetron === 1'b1) on++;
                step();
            end
            vectors++;
            if (on != 2 * PT * m_pwr) begin
                miscompares++;
                $display("FAIL duty_count got %0d want %0d", on, 2 * PT * m_pwr);
            end
            stop_cook();
        end
    endtask

    task automatic test_door_and_finish();
        int cnt;
        press(4'd10); press(4'd2); press(4'd0);
        press_start();
        timer_done = 1'b0;
        step();
        vectors++;
        if (magnetron !== 1'b1) begin
            miscompares++;
            $display("FAIL door_pre_mag got %b want 1", magnetron);
        end
        door_open = 1'b1;
        #1;
        vectors++;
        if (magnetron !== 1'b0 || lamp !== 1'b1 || timer_pause !== 1'b0) begin
            miscompares++;
            $display("FAIL door_comb mag=%b lamp=%b pause=%b want 0 1 0",
                     magnetron, lamp, timer_pause);
        end
        step();
        vectors++;
        if (timer_pause !== 1'b1 || magnetron !== 1'b0 || lamp !== 1'b1) begin
            miscompares++;
            $display("FAIL door_pause pause=%b mag=%b lamp=%b want 1 0 1",
                     timer_pause, magnetron, lamp);
        end
        step();
        press_start();
        vectors++;
        if (timer_pause !== 1'b0 || timer_start !== 1'b0) begin
            miscompares++;
            $display("FAIL paused_door_start pause=%b start=%b want 0 0",
                     timer_pause, timer_start);
        end
        door_open = 1'b0;
        step();
        vectors++;
        if (lamp !== 1'b1 || magnetron !== 1'b0) begin
            miscompares++;
            $display("FAIL paused_lamp lamp=%b mag=%b want 1 0", lamp, magnetron);
        end
        press_start();
        vectors++;
        if (timer_start !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_start got %b want 1", timer_start);
        end
        step();
        vectors++;
        if (magnetron !== 1'b1 || lamp !== 1'b1 || timer_start !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_cook mag=%b lamp=%b start=%b want 1 1 0",
                     magnetron, lamp, timer_start);
        end
        key_valid = 1'b1;
        key_code  = 4'd7;
        step();
        key_valid = 1'b0;
        step();
        vectors++;
        if (min !== 7'(exp_min()) || sec !== 7'(exp_sec())) begin
            miscompares++;
            $display("FAIL cook_key_ignored got %0d:%0d want %0d:%0d",
                     min, sec, exp_min(), exp_sec());
        end
        timer_done = 1'b1;
        step();
        vectors++;
        if (magnetron !== 1'b0 || lamp !== 1'b0) begin
            miscompares++;
            $display("FAIL finish_outputs mag=%b lamp=%b want 0 0", magnetron, lamp);
        end
        cnt = 0;
        while (beep === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        vectors++;
        if (cnt != BC) begin
            miscompares++;
            $display("FAIL beep_length got %0d want %0d", cnt, BC);
        end
        m_val = 0;
        vectors++;
        if (min !== 7'd0 || sec !== 7'd0) begin
            miscompares++;
            $display("FAIL finish_clear got %0d:%0d want 0:0", min, sec);
        end
    endtask

    task automatic test_quick();
        door_open = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd11;
        step();
        key_valid = 1'b0;
        door_open = 1'b0;
        vectors++;
        if (timer_start !== 1'b0 || sec !== 7'(exp_sec())) begin
            miscompares++;
            $display("FAIL quick_door start=%b sec=%0d want 0 %0d",
                     timer_start, sec, exp_sec());
        end
        step();
        key_valid = 1'b1;
        key_code  = 4'd11;
        step();
        key_valid = 1'b0;
        m_val = 30;
        vectors++;
        if (min !== 7'd0 || sec !== 7'd30 || timer_start !== 1'b1) begin
            miscompares++;
            $display("FAIL quick_start %0d:%0d start=%b want 0:30 1",
                     min, sec, timer_start);
        end
        timer_done = 1'b0;
        step();
        vectors++;
        if (magnetron !== 1'b1) begin
            miscompares++;
            $display("FAIL quick_cook mag=%b want 1", magnetron);
        end
        stop_cook();
    endtask

    task automatic test_back_to_back();
        press(4'd1); press(4'd0); press(4'd0);
        press_start();
        timer_done = 1'b0;
        step();
        door_open = 1'b1;
        step();
        door_open = 1'b0;
        step();
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        step();
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        m_val = 0;
        vectors++;
        if (timer_stop !== 1'b1 || timer_start !== 1'b0 || timer_pause !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_start_same stop=%b start=%b pause=%b want 1 0 0",
                     timer_stop, timer_start, timer_pause);
        end
        timer_done = 1'b1;
        step();
        vectors++;
        if (lamp !== 1'b0 || magnetron !== 1'b0 || timer_stop !== 1'b0 ||
            min !== 7'd0 || sec !== 7'd0) begin
            miscompares++;
            $display("FAIL stop_start_idle lamp=%b mag=%b stop=%b %0d:%0d want 0 0 0 0:0",
                     lamp, magnetron, timer_stop, min, sec);
        end
    endtask

    task automatic test_arm_timeout();
        int cnt;
        int extra_start;
        press(4'd10); press(4'd4);
        press_start();
        vectors++;
        if (timer_start !== 1'b1) begin
            miscompares++;
            $display("FAIL arm_start got %b want 1", timer_start);
        end
        cnt = 0;
        extra_start = 0;
        do begin
            step();
            cnt++;
            if (timer_start === 1'b1) extra_start++;
        end while (timer_stop !== 1'b1 && cnt < 40);
        vectors++;
        if (cnt != AT || extra_start != 0) begin
            miscompares++;
            $display("FAIL arm_timeout got %0d cycles %0d restarts want %0d 0",
                     cnt, extra_start, AT);
        end
        step();
        press(4'd3);
        vectors++;
        if (min !== 7'(exp_min()) || sec !== 7'(exp_sec())) begin
            miscompares++;
            $display("FAIL arm_back_idle got %0d:%0d want %0d:%0d",
                     min, sec, exp_min(), exp_sec());
        end
    endtask

    task automatic test_reset_mid_cook();
        press(4'd12); press(4'd12);
        press(4'd10); press(4'd5); press(4'd0);
        press_start();
        timer_done = 1'b0;
        step();
        vectors++;
        if (magnetron !== 1'b1 || power !== 4'(m_pwr)) begin
            miscompares++;
            $display("FAIL pre_reset mag=%b pwr=%0d want 1 %0d",
                     magnetron, power, m_pwr);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (min !== 7'd0 || sec !== 7'd0 || power !== 4'd10 ||
            {timer_start, timer_pause, timer_stop} !== 3'b000 ||
            {magnetron, lamp, beep} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset %0d:%0d pwr=%0d pulses=%b%b%b mlb=%b%b%b want 0:0 10 000 000",
                     min, sec, power, timer_start, timer_pause, timer_stop,
                     magnetron, lamp, beep);
        end
        timer_done = 1'b1;
        step();
        reset = 1'b0;
        m_val = 0;
        m_pwr = 10;
        step();
        vectors++;
        if ({timer_start, timer_pause, timer_stop} !== 3'b000 || power !== 4'd10) begin
            miscompares++;
            $display("FAIL post_reset pulses=%b%b%b pwr=%0d want 000 10",
                     timer_start, timer_pause, timer_stop, power);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        start_btn  = 1'b0;
        stop_btn   = 1'b0;
        door_open  = 1'b0;
        timer_done = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b0;
        step();
        test_reset();
        test_entry();
        test_digits_random();
        test_power_duty();
        test_door_and_finish();
        test_quick();
        test_back_to_back();
        test_arm_timeout();
        test_reset_mid_cook();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
